// File: rtl/shift_pkg.sv
// Shared types and default widths for the execute-stage shift arbiter.
package shift_pkg;

    localparam int unsigned SHIFT_DATA_W  = 32;
    localparam int unsigned SHIFT_SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SRA = 2'b01,
        SH_SLL = 2'b10,
        SH_RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter; output is forced to zero unless execute_i is high.
module shift_core
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W  = SHIFT_DATA_W,
    parameter int unsigned SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_e          op_i,
    input  logic               execute_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               err_o
);

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        if (execute_i) begin
            unique case (op_i)
                SH_SLL:  result_o = data_i << shamt_i;
                SH_SRL:  result_o = data_i >> shamt_i;
                SH_SRA:  result_o = DATA_W'($signed(data_i) >>> shamt_i);
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port request arbiter and IDLE/EXEC/RESP sequencer around shift_core.
// Define SHIFT_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins ties.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W  = SHIFT_DATA_W,
    parameter int unsigned SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [DATA_W-1:0]  req0_data,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [DATA_W-1:0]  req1_data,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err
);

    state_e              state_q, state_d;
    shift_op_e           op_q, op_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_id_q, rsp_id_d;

    logic                prefer0_c;
    logic                grant0_c;
    logic                grant1_c;
    logic                execute_c;
    logic [DATA_W-1:0]   core_result;
    logic                core_err;

`ifdef SHIFT_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // last_grant == 1 means port 1 was served last, so port 0 wins the next tie
    assign prefer0_c = last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == IDLE) && (grant0_c || grant1_c)) begin
            last_grant_d = grant1_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign prefer0_c = 1'b1;
`endif

    assign grant0_c = req0_valid && (!req1_valid || prefer0_c);
    assign grant1_c = req1_valid && !grant0_c;

    shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .data_i    (data_q),
        .shamt_i   (shamt_q),
        .op_i      (op_q),
        .execute_i (execute_c),
        .result_o  (core_result),
        .err_o     (core_err)
    );

    // Next-state, grant and register-load decisions
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        shamt_d    = shamt_q;
        data_d     = data_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        execute_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant0_c || grant1_c) begin
                    req0_ready = grant0_c;
                    req1_ready = grant1_c;
                    id_d       = grant1_c;
                    op_d       = shift_op_e'(grant1_c ? req1_op : req0_op);
                    shamt_d    = grant1_c ? req1_shamt : req0_shamt;
                    data_d     = grant1_c ? req1_data : req0_data;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                execute_c  = 1'b1;
                rsp_data_d = core_result;
                rsp_err_d  = core_err;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= SH_SRL;
            shamt_q    <= '0;
            data_q     <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            shamt_q    <= shamt_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed cases, stall, reset, ties, then random traffic.
module tb_shift_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    typedef struct packed {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_ready, req1_ready;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [DW-1:0] rsp_data;

    logic          pend  [2] = '{1'b0, 1'b0};
    logic [1:0]    p_op  [2] = '{2'b00, 2'b00};
    logic [SW-1:0] p_sh  [2] = '{'0, '0};
    logic [DW-1:0] p_dat [2] = '{'0, '0};

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
`ifdef SHIFT_ARB_RR_EN
    logic m_last = 1'b1;
`endif

    shift_arbiter #(.DATA_W(DW), .SHAMT_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (pend[0]),
        .req0_ready (req0_ready),
        .req0_op    (p_op[0]),
        .req0_shamt (p_sh[0]),
        .req0_data  (p_dat[0]),
        .req1_valid (pend[1]),
        .req1_ready (req1_ready),
        .req1_op    (p_op[1]),
        .req1_shamt (p_sh[1]),
        .req1_data  (p_dat[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Reference: shift semantics written from the operation rules
    function automatic exp_t model(input logic id, input logic [1:0] op,
                                   input logic [SW-1:0] sh, input logic [DW-1:0] d);
        exp_t          e;
        logic [DW-1:0] ones;
        ones  = '1;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            2'b10:   e.data = d * (DW'(1) << sh);
            2'b00:   e.data = d >> sh;
            2'b01:   e.data = (d >> sh) | (d[DW-1] ? ~(ones >> sh) : '0);
            default: begin e.data = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic pick();
        if (pend[0] && pend[1]) begin
`ifdef SHIFT_ARB_RR_EN
            return ~m_last;
`else
            return 1'b0;
`endif
        end
        return pend[1];
    endfunction

    task automatic add_req(input int p, input logic [1:0] op, input logic [SW-1:0] sh,
                           input logic [DW-1:0] d);
        p_op[p]  = op;
        p_sh[p]  = sh;
        p_dat[p] = d;
        pend[p]  = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready within 60 cycles expected a grant", name);
            finish_sim();
        end
    endtask

    // Issue the model's predicted winner, queue its result, check grant and latency
    task automatic run_grant(output int gcyc);
        logic w;
        w = pick();
        exp_q.push_back(model(w, p_op[w], p_sh[w], p_dat[w]));
        wait_ready("grant");
        check("grant", 64'({req1_ready, req0_ready}), 64'(w ? 2'b10 : 2'b01));
        gcyc = cyc;
`ifdef SHIFT_ARB_RR_EN
        m_last = w;
`endif
        @(posedge clk);
        #1;
        pend[w] = 1'b0;
        @(negedge clk);
        check("exec_no_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("latency", 64'(rsp_valid), 64'(1));
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each response handshake, checks hold and ready rules
    initial begin : mon
        exp_t            e;
        logic            pv;
        logic [DW+1:0]   prev;
        pv   = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv) begin
                    check("stall_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}), 64'({1'b1, prev}));
                end
                if (rsp_valid) begin
                    check("ready_in_resp", 64'({req1_ready, req0_ready}), 64'(0));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d data %0h expected no response", rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", 64'({rsp_id, rsp_err, rsp_data}), 64'({e.id, e.err, e.data}));
                    end
                end
                pv   = rsp_valid && !rsp_ready;
                prev = {rsp_id, rsp_err, rsp_data};
            end else begin
                pv = 1'b0;
            end
        end
    end

    initial begin : drv
        int g;
        int gprev;
        g     = 0;
        gprev = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single-port operations
        rdy_mode = 0;
        add_req(0, 2'b10, 5'd4, 32'h0000_00F1); run_grant(g);
        add_req(1, 2'b01, 5'd8, 32'h8000_1234); run_grant(g);
        add_req(1, 2'b00, 5'd8, 32'h8000_1234); run_grant(g);
        add_req(0, 2'b11, 5'd3, 32'hFFFF_FFFF); run_grant(g);
        add_req(0, 2'b10, 5'd0, 32'hA5A5_A5A5); run_grant(g);
        add_req(1, 2'b01, 5'd31, 32'h8000_0000); run_grant(g);

        // Consumer stall for five cycles in RESP
        rdy_mode = 2;
        add_req(0, 2'b01, 5'd4, 32'h8000_00F0);
        run_grant(g);
        repeat (5) @(negedge clk);
        check("stall_valid", 64'(rsp_valid), 64'(1));
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_hs", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;

        // Reset while EXEC: result discarded, tie state returns to reset value
        add_req(0, 2'b10, 5'd3, 32'h0000_0001);
        wait_ready("rst_grant");
        check("rst_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(posedge clk);
        #1;
        pend[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_in_exec", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data}), 64'(0));
`ifdef SHIFT_ARB_RR_EN
        m_last = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Both ports requesting back to back
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) add_req(p, 2'($urandom_range(0, 2)), SW'($urandom), $urandom);
            end
            run_grant(g);
            if (k > 0) check("throughput", 64'(g - gprev), 64'(3));
            gprev = g;
        end
        while (pend[0] || pend[1]) run_grant(g);

        // Random traffic with a random consumer
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1))
                    add_req(p, 2'($urandom_range(0, 3)), SW'($urandom), $urandom);
            end
            if (!pend[0] && !pend[1])
                add_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), SW'($urandom), $urandom);
            run_grant(g);
        end
        while (pend[0] || pend[1]) run_grant(g);

        rdy_mode = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        finish_sim();
    end

endmodule
